// File: rtl/lzc_iterative_pkg.sv
// Shared definitions for the iterative bit-scan engine: scan-mode
// encodings and the controller state type.
package lzc_iterative_pkg;

  localparam logic [1:0] MODE_LZ = 2'b00;  // leading zeros
  localparam logic [1:0] MODE_LO = 2'b01;  // leading ones
  localparam logic [1:0] MODE_TZ = 2'b10;  // trailing zeros
  localparam logic [1:0] MODE_TO = 2'b11;  // trailing ones

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/lzc_iterative_if.sv
// Producer/consumer bundle for the bit-scan engine.
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// clk edge where valid and ready are both 1. Once valid is raised the
// source holds valid and its payload unchanged until that transfer edge;
// ready may change freely and never depends combinationally on valid.
interface lzc_iterative_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_all;

  // Producer of words and consumer of results.
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_all
  );

  // The scan engine itself.
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_all
  );
endinterface

// File: rtl/lzc_iterative_chunk.sv
// Combinational leading-zero count of one CHUNK-bit slice. count is CHUNK
// when the slice is all zero; nonzero flags that a terminating bit exists.
module lzc_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]         data,
  output logic [$clog2(CHUNK):0]   count,
  output logic                     nonzero
);
  localparam int LW = $clog2(CHUNK) + 1;

  // Scan LSB to MSB so the most significant set bit wins.
  always_comb begin
    count   = LW'(CHUNK);
    nonzero = |data;
    for (int i = 0; i < CHUNK; i++) begin
      if (data[i]) count = LW'(CHUNK - 1 - i);
    end
  end
endmodule

// File: rtl/lzc_iterative.sv
// Multi-cycle leading/trailing zero/one counter. The accepted word is
// transformed once (invert for ones modes, bit-reverse for trailing modes)
// so the scan core only ever counts leading zeros, CHUNK bits per cycle,
// stopping at the first chunk that holds a set bit.
module lzc_iterative
  import lzc_iterative_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  lzc_iterative_if.slave bus,
  output state_t         dbg_state
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW  = $clog2(CHUNK) + 1;

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("lzc_iterative: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_all_q, out_all_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [WIDTH-1:0] cap_word;
  logic [WIDTH-1:0] cap_inv;
  logic             cap_ones;
  logic             cap_trail;
  logic [LW-1:0]    chunk_lz;
  logic             chunk_nz;

  lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
    .data    (shreg_q[WIDTH-1 -: CHUNK]),
    .count   (chunk_lz),
    .nonzero (chunk_nz)
  );

  // Map every mode onto a leading-zero scan of the captured word.
  always_comb begin
    cap_ones  = (bus.in_mode == MODE_LO) || (bus.in_mode == MODE_TO);
    cap_trail = (bus.in_mode == MODE_TZ) || (bus.in_mode == MODE_TO);
    cap_inv   = cap_ones ? ~bus.in_data : bus.in_data;
    cap_word  = cap_inv;
    if (cap_trail) begin
      for (int i = 0; i < WIDTH; i++) cap_word[i] = cap_inv[WIDTH-1-i];
    end
  end

  // Controller: accept in IDLE, one chunk per SCAN cycle, hold in DONE.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_all_d   = out_all_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          shreg_d    = cap_word;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (chunk_nz) begin
          acc_d       = acc_q + CW'(chunk_lz);
          out_count_d = acc_q + CW'(chunk_lz);
          out_all_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == IW'(NCH - 1)) begin
          acc_d       = CW'(WIDTH);
          out_count_d = CW'(WIDTH);
          out_all_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d   = acc_q + CW'(CHUNK);
          shreg_d = shreg_q << CHUNK;
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_all_q   <= 1'b0;
      shreg_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_all_q   <= out_all_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_all   = out_all_q;
  assign dbg_state     = state_q;
endmodule
